// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter with a runtime-configurable frame.
// Frames (start / data LSB first / optional parity / 1-2 stop) go out back-to-back while words are queued.
module uart_tx_buffered #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [DATA_WIDTH-1:0]       P_DATA,
    input  logic                        DATA_VALID,
    output logic                        DATA_READY,
    input  logic                        PAR_EN,
    input  logic                        PAR_TYP,
    input  logic                        STOP2,
    input  logic [PRESCALE_W-1:0]       PRESCALE,
    output logic                        TX_OUT,
    output logic                        Busy,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BW-1:0]         bit_cnt;
    logic [PRESCALE_W-1:0] baud_cnt;
    logic [PRESCALE_W-1:0] presc_l;
    logic                  par_en_l;
    logic                  stop2_l;
    logic                  par_bit_l;
    logic                  stop_cnt;
    logic                  push;
    logic                  pop;
    logic                  bit_end;
    logic                  fifo_empty;

    assign fifo_empty = (level == '0);
    assign DATA_READY = (level != LW'(FIFO_DEPTH));
    assign FIFO_LEVEL = level;
    assign head       = mem[rd_ptr];
    assign bit_end    = (baud_cnt == presc_l);
    assign push       = DATA_VALID && DATA_READY;

    // Pop is decoded once here so the FIFO pointers and the FSM load agree on the same edge.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == IDLE)
                pop = 1'b1;
            else if ((state == STOP) && bit_end && (stop_cnt || !stop2_l))
                pop = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= P_DATA;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            presc_l   <= '0;
            par_en_l  <= 1'b0;
            stop2_l   <= 1'b0;
            par_bit_l <= 1'b0;
            stop_cnt  <= 1'b0;
        end else if (pop) begin
            shift_reg <= head;
            presc_l   <= PRESCALE;
            par_en_l  <= PAR_EN;
            stop2_l   <= STOP2;
            par_bit_l <= PAR_TYP ? ~^head : ^head;
            state     <= START;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
            baud_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        TX_OUT   <= shift_reg[0];
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            if (par_en_l) begin
                                state  <= PARITY;
                                TX_OUT <= par_bit_l;
                            end else begin
                                state    <= STOP;
                                TX_OUT   <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            TX_OUT    <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        TX_OUT   <= 1'b1;
                        stop_cnt <= 1'b0;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (stop2_l && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            TX_OUT <= 1'b1;
                            Busy   <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule
